// File: rtl/ftdi_stream_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ftdi_pkg
//  Purpose  : Shared constants and FSM state types for the FTDI stream bridge
//  Revision : 1.0 - initial release
// ============================================================================
package ftdi_pkg;

    // Width of one byte on every controller and top-level data path
    localparam int FTDI_BYTE_W      = 8;

    // FIFO address width used when the instantiating level does not override it
    localparam int FTDI_FIFO_AW_DEF = 4;

    // TX interlock state encodings
    localparam logic [1:0] TX_IDLE_ENC = 2'd0;
    localparam logic [1:0] TX_REQ_ENC  = 2'd1;
    localparam logic [1:0] TX_DROP_ENC = 2'd2;

    // RX interlock state encodings
    localparam logic [0:0] RX_IDLE_ENC = 1'b0;
    localparam logic [0:0] RX_ACK_ENC  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE = TX_IDLE_ENC,
        TX_REQ  = TX_REQ_ENC,
        TX_DROP = TX_DROP_ENC
    } tx_state_e;

    typedef enum logic [0:0] {
        RX_IDLE = RX_IDLE_ENC,
        RX_ACK  = RX_ACK_ENC
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/ftdi_stream_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : ftdi_stream_bridge_if
//  Purpose  : Top-level byte streams plus controller interlock signals
//  Revision : 1.0 - initial release
// ============================================================================
interface ftdi_stream_bridge_if
    import ftdi_pkg::*;
#(
    parameter int FIFO_AW = FTDI_FIFO_AW_DEF
) ();

    // Top-level TX stream
    logic                   in_tx_valid;
    logic                   out_tx_ready;
    logic [FTDI_BYTE_W-1:0] in_tx_byte;

    // Top-level RX stream
    logic                   out_rx_valid;
    logic                   in_rx_ready;
    logic [FTDI_BYTE_W-1:0] out_rx_byte;
    logic                   in_rx_allow;

    // Controller TX interlock
    logic                   out_ctl_tx_hsk_req;
    logic                   in_ctl_tx_hsk_ack;
    logic [FTDI_BYTE_W-1:0] out_ctl_tx_data;

    // Controller RX interlock
    logic                   in_ctl_rx_hsk_req;
    logic                   out_ctl_rx_hsk_ack;
    logic [FTDI_BYTE_W-1:0] in_ctl_rx_data;
    logic                   out_ctl_rx_en;

    // FIFO occupancy
    logic [FIFO_AW:0]       out_tx_level;
    logic [FIFO_AW:0]       out_rx_level;

    // Bridge side
    modport slave (
        input  in_tx_valid, in_tx_byte, in_rx_ready, in_rx_allow,
               in_ctl_tx_hsk_ack, in_ctl_rx_hsk_req, in_ctl_rx_data,
        output out_tx_ready, out_rx_valid, out_rx_byte,
               out_ctl_tx_hsk_req, out_ctl_tx_data, out_ctl_rx_hsk_ack,
               out_ctl_rx_en, out_tx_level, out_rx_level
    );

    // Driving side (top-level logic and controller together)
    modport master (
        output in_tx_valid, in_tx_byte, in_rx_ready, in_rx_allow,
               in_ctl_tx_hsk_ack, in_ctl_rx_hsk_req, in_ctl_rx_data,
        input  out_tx_ready, out_rx_valid, out_rx_byte,
               out_ctl_tx_hsk_req, out_ctl_tx_data, out_ctl_rx_hsk_ack,
               out_ctl_rx_en, out_tx_level, out_rx_level
    );

endinterface
`default_nettype wire

// File: rtl/ftdi_stream_bridge_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : byte_fifo
//  Purpose  : Synchronous first-word-fall-through byte FIFO, depth 2**AW
//  Revision : 1.0 - initial release
// ============================================================================
module byte_fifo
    import ftdi_pkg::*;
#(
    parameter int AW = FTDI_FIFO_AW_DEF
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push_i,
    input  wire logic [FTDI_BYTE_W-1:0] wdata_i,
    input  wire logic                   pop_i,
    output logic      [FTDI_BYTE_W-1:0] rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic      [AW:0]            level_o
);

    localparam int          c_depth     = 2 ** AW;
    localparam logic [AW:0] c_depth_w   = (AW+1)'(c_depth);
    localparam logic [AW:0] c_level_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [FTDI_BYTE_W-1:0] mem_q [c_depth];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            level_q;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop_ok;
    logic                   w_push_ok;

    assign w_full    = (level_q == c_depth_w);
    assign w_empty   = (level_q == '0);
    assign w_pop_ok  = pop_i && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign w_push_ok = push_i && (!w_full || w_pop_ok);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + c_ptr_one;
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + c_ptr_one;
            end
            if (w_push_ok && !w_pop_ok) begin
                level_q <= level_q + c_level_one;
            end else if (w_pop_ok && !w_push_ok) begin
                level_q <= level_q - c_level_one;
            end
        end
    end

    // Storage write; contents need no reset since the head is masked when empty
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = w_empty ? '0 : mem_q[rd_ptr_q];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/ftdi_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ftdi_stream_bridge
//  Purpose  : Converts the FTDI controller 4-phase TX/RX interlocks into two
//             buffered valid/ready byte streams and paces the controller's
//             RX enable so received bytes always find room.
//  Revision : 1.0 - initial release
// ============================================================================
module ftdi_stream_bridge
    import ftdi_pkg::*;
#(
    parameter int FIFO_AW     = FTDI_FIFO_AW_DEF,
    parameter int RX_HEADROOM = 2
) (
    input  wire logic            in_clk,
    input  wire logic            in_rst,
    ftdi_stream_bridge_if.slave  bus
);

    localparam logic [FIFO_AW:0] c_depth    = (FIFO_AW+1)'(2 ** FIFO_AW);
    localparam logic [FIFO_AW:0] c_headroom = (FIFO_AW+1)'(RX_HEADROOM);

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic [FTDI_BYTE_W-1:0] w_tx_head;
    logic                   w_tx_full;
    logic                   w_tx_empty;
    logic [FIFO_AW:0]       w_tx_level;
    logic                   w_tx_pop;

    logic [FTDI_BYTE_W-1:0] w_rx_head;
    logic                   w_rx_full;
    logic                   w_rx_empty;
    logic [FIFO_AW:0]       w_rx_level;
    logic                   w_rx_push;
    logic                   w_rx_pop;

    byte_fifo #(
        .AW      (FIFO_AW)
    ) u_tx_fifo (
        .clk     (in_clk),
        .rst     (in_rst),
        .push_i  (bus.in_tx_valid),
        .wdata_i (bus.in_tx_byte),
        .pop_i   (w_tx_pop),
        .rdata_o (w_tx_head),
        .full_o  (w_tx_full),
        .empty_o (w_tx_empty),
        .level_o (w_tx_level)
    );

    byte_fifo #(
        .AW      (FIFO_AW)
    ) u_rx_fifo (
        .clk     (in_clk),
        .rst     (in_rst),
        .push_i  (w_rx_push),
        .wdata_i (bus.in_ctl_rx_data),
        .pop_i   (bus.in_rx_ready),
        .rdata_o (w_rx_head),
        .full_o  (w_rx_full),
        .empty_o (w_rx_empty),
        .level_o (w_rx_level)
    );

    assign w_rx_pop = bus.in_rx_ready && !w_rx_empty;

    // ------------------------------------------------------------------
    // TX interlock FSM
    // ------------------------------------------------------------------
    tx_state_e              tx_state_q, tx_state_d;
    logic                   tx_req_q,   tx_req_d;
    logic [FTDI_BYTE_W-1:0] tx_data_q,  tx_data_d;

    // TX state, request and output data registers
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            tx_state_q <= TX_IDLE;
            tx_req_q   <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_req_q   <= tx_req_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // TX next state; data is only reloaded on the ack cycle, when the
    // controller has finished its previous write and no longer samples it
    always_comb begin
        tx_state_d = tx_state_q;
        tx_req_d   = tx_req_q;
        tx_data_d  = tx_data_q;
        w_tx_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_req_d = 1'b0;
                if (!w_tx_empty && !bus.in_ctl_tx_hsk_ack) begin
                    tx_req_d   = 1'b1;
                    tx_state_d = TX_REQ;
                end
            end
            TX_REQ: begin
                tx_req_d = 1'b1;
                if (bus.in_ctl_tx_hsk_ack) begin
                    tx_data_d  = w_tx_head;
                    w_tx_pop   = 1'b1;
                    tx_req_d   = 1'b0;
                    tx_state_d = TX_DROP;
                end
            end
            TX_DROP: begin
                tx_req_d = 1'b0;
                if (!bus.in_ctl_tx_hsk_ack) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_req_d   = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX interlock FSM
    // ------------------------------------------------------------------
    rx_state_e rx_state_q, rx_state_d;
    logic      rx_ack_q,   rx_ack_d;
    logic      rx_ovf_q;
    logic      w_rx_overflow;

    // RX state and acknowledge registers
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            rx_state_q <= RX_IDLE;
            rx_ack_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_ack_q   <= rx_ack_d;
        end
    end

    // RX next state; the byte is captured once, on the first req cycle
    always_comb begin
        rx_state_d = rx_state_q;
        rx_ack_d   = rx_ack_q;
        w_rx_push  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_ack_d = 1'b0;
                if (bus.in_ctl_rx_hsk_req) begin
                    w_rx_push  = 1'b1;
                    rx_ack_d   = 1'b1;
                    rx_state_d = RX_ACK;
                end
            end
            RX_ACK: begin
                rx_ack_d = 1'b1;
                if (!bus.in_ctl_rx_hsk_req) begin
                    rx_ack_d   = 1'b0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_ack_d   = 1'b0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // A push that the FIFO cannot take is still acknowledged but the byte is lost
    assign w_rx_overflow = w_rx_push && w_rx_full && !w_rx_pop;

    // Sticky record of any lost RX byte
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            rx_ovf_q <= 1'b0;
        end else if (w_rx_overflow) begin
            rx_ovf_q <= 1'b1;
        end
    end

    a_no_rx_overflow: assert property (@(posedge in_clk) disable iff (in_rst) !rx_ovf_q);

    // ------------------------------------------------------------------
    // RX enable pacing
    // ------------------------------------------------------------------
    logic             rx_en_q, rx_en_d;
    logic [FIFO_AW:0] w_rx_free;

    assign w_rx_free = c_depth - w_rx_level;
    // Headroom covers the byte already in flight plus this register's one-cycle lag
    assign rx_en_d   = bus.in_rx_allow && (w_rx_free >= c_headroom);

    // Registered RX enable
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            rx_en_q <= 1'b0;
        end else begin
            rx_en_q <= rx_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out_tx_ready       = !w_tx_full;
    assign bus.out_rx_valid       = !w_rx_empty;
    assign bus.out_rx_byte        = w_rx_head;
    assign bus.out_ctl_tx_hsk_req = tx_req_q;
    assign bus.out_ctl_tx_data    = tx_data_q;
    assign bus.out_ctl_rx_hsk_ack = rx_ack_q;
    assign bus.out_ctl_rx_en      = rx_en_q;
    assign bus.out_tx_level       = w_tx_level;
    assign bus.out_rx_level       = w_rx_level;

endmodule
`default_nettype wire

// File: tb/tb_ftdi_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ftdi_stream_bridge
//  Purpose  : Directed self-checking bench for ftdi_stream_bridge
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ftdi_stream_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ftdi_stream_bridge_if #(.FIFO_AW(4)) bus ();

    ftdi_stream_bridge #(
        .FIFO_AW     (4),
        .RX_HEADROOM (2)
    ) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    // Top-level side drives
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       rx_ready;
    logic       rx_allow;

    // Controller models: auto mode follows the interlock, manual mode is hand-driven
    logic       tx_auto, tx_ack_en, tx_ack_m, tx_ack_man;
    logic       rx_auto, rx_req_m, rx_req_man;
    logic [7:0] rx_data_m, rx_data_man;
    logic [7:0] rx_src [0:31];
    int         rx_send_cnt;
    int         rx_send_idx = 0;

    // Observation records
    logic [7:0] tx_got [0:63];
    int         tx_got_n    = 0;
    logic [7:0] rx_got [0:63];
    int         rx_got_n    = 0;
    int         tx_accepted = 0;
    int         tx_unstable = 0;
    logic [7:0] tx_last     = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    assign bus.in_tx_valid       = tx_valid;
    assign bus.in_tx_byte        = tx_byte;
    assign bus.in_rx_ready       = rx_ready;
    assign bus.in_rx_allow       = rx_allow;
    assign bus.in_ctl_tx_hsk_ack = tx_auto ? tx_ack_m : tx_ack_man;
    assign bus.in_ctl_rx_hsk_req = rx_auto ? rx_req_m : rx_req_man;
    assign bus.in_ctl_rx_data    = rx_auto ? rx_data_m : rx_data_man;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx_ack(input logic lvl, input string tag);
        for (int i = 0; i < 20 && bus.out_ctl_rx_hsk_ack !== lvl; i++) tick();
        check(tag, 32'(bus.out_ctl_rx_hsk_ack), 32'(lvl));
    endtask

    task automatic wait_tx_req(input string tag);
        for (int i = 0; i < 20 && bus.out_ctl_tx_hsk_req !== 1'b1; i++) tick();
        check(tag, 32'(bus.out_ctl_tx_hsk_req), 32'd1);
    endtask

    task automatic rx_manual_byte(input logic [7:0] b);
        rx_data_man = b;
        rx_req_man  = 1'b1;
        wait_rx_ack(1'b1, "rx_man_ack_hi");
        rx_req_man  = 1'b0;
        wait_rx_ack(1'b0, "rx_man_ack_lo");
    endtask

    // TX controller: ack follows req one cycle later while enabled
    always @(posedge clk) begin
        if (rst) tx_ack_m <= 1'b0;
        else     tx_ack_m <= bus.out_ctl_tx_hsk_req && tx_ack_en;
    end

    // TX controller capture; data may only move in the cycle right after the ack
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_ctl_tx_hsk_ack && !bus.out_ctl_tx_hsk_req) begin
                tx_got[tx_got_n] <= bus.out_ctl_tx_data;
                tx_got_n         <= tx_got_n + 1;
            end else if (bus.out_ctl_tx_data != tx_last) begin
                tx_unstable <= tx_unstable + 1;
            end
        end
        tx_last <= bus.out_ctl_tx_data;
    end

    // RX controller: sends queued bytes only while rx_en is high
    always @(posedge clk) begin
        if (rst) begin
            rx_req_m <= 1'b0;
        end else if (rx_auto) begin
            if (rx_req_m) begin
                if (bus.out_ctl_rx_hsk_ack) rx_req_m <= 1'b0;
            end else if (!bus.out_ctl_rx_hsk_ack && bus.out_ctl_rx_en && rx_send_idx < rx_send_cnt) begin
                rx_req_m    <= 1'b1;
                rx_data_m   <= rx_src[rx_send_idx];
                rx_send_idx <= rx_send_idx + 1;
            end
        end
    end

    // Top-level stream monitors
    always @(posedge clk) begin
        if (!rst && tx_valid && bus.out_tx_ready) tx_accepted <= tx_accepted + 1;
        if (!rst && rx_ready && bus.out_rx_valid) begin
            rx_got[rx_got_n] <= bus.out_rx_byte;
            rx_got_n         <= rx_got_n + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1; tx_valid = 1'b0; tx_byte = 8'h00; rx_ready = 1'b0; rx_allow = 1'b0;
        tx_auto = 1'b1; tx_ack_en = 1'b1; tx_ack_man = 1'b0;
        rx_auto = 1'b1; rx_req_man = 1'b0; rx_data_man = 8'h00; rx_data_m = 8'h00;
        rx_send_cnt = 0;
        tick(3);

        // Reset state
        check("rst_tx_ready", 32'(bus.out_tx_ready), 32'd1);
        check("rst_rx_valid", 32'(bus.out_rx_valid), 32'd0);
        check("rst_rx_byte",  32'(bus.out_rx_byte), 32'h00);
        check("rst_tx_req",   32'(bus.out_ctl_tx_hsk_req), 32'd0);
        check("rst_rx_ack",   32'(bus.out_ctl_rx_hsk_ack), 32'd0);
        check("rst_tx_data",  32'(bus.out_ctl_tx_data), 32'h00);
        check("rst_rx_en",    32'(bus.out_ctl_rx_en), 32'd0);
        check("rst_tx_level", 32'(bus.out_tx_level), 32'd0);
        check("rst_rx_level", 32'(bus.out_rx_level), 32'd0);
        rst = 1'b0;
        tick();

        // TX single byte, controller acks one cycle after req
        tx_valid = 1'b1; tx_byte = 8'hA5;
        tick();
        tx_valid = 1'b0;
        check("tx1_level_1", 32'(bus.out_tx_level), 32'd1);
        check("tx1_req_lo",  32'(bus.out_ctl_tx_hsk_req), 32'd0);
        tick();
        check("tx1_req_hi",  32'(bus.out_ctl_tx_hsk_req), 32'd1);
        tick();
        check("tx1_ack_hi",  32'(bus.in_ctl_tx_hsk_ack), 32'd1);
        check("tx1_data_old", 32'(bus.out_ctl_tx_data), 32'h00);
        tick();
        check("tx1_data",    32'(bus.out_ctl_tx_data), 32'hA5);
        check("tx1_req_fall", 32'(bus.out_ctl_tx_hsk_req), 32'd0);
        check("tx1_level_0", 32'(bus.out_tx_level), 32'd0);
        tick(4);
        check("tx1_got_n",   32'(tx_got_n), 32'd1);
        check("tx1_got",     32'(tx_got[0]), 32'hA5);

        // TX burst with the controller stalled, then released
        tx_ack_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tx_valid = 1'b1; tx_byte = 8'(i);
            tick();
        end
        tx_byte = 8'h11;
        tick(3);
        tx_valid = 1'b0;
        check("burst_ready_lo", 32'(bus.out_tx_ready), 32'd0);
        check("burst_level",    32'(bus.out_tx_level), 32'd16);
        check("burst_accepted", 32'(tx_accepted), 32'd17);
        tx_ack_en = 1'b1;
        for (int i = 0; i < 300 && tx_got_n < 17; i++) tick();
        tick(4);
        check("burst_got_n", 32'(tx_got_n), 32'd17);
        for (int i = 1; i <= 16; i++) check("burst_byte", 32'(tx_got[i]), 32'(i));
        check("burst_level_0",  32'(bus.out_tx_level), 32'd0);
        check("burst_ready_hi", 32'(bus.out_tx_ready), 32'd1);
        check("tx_data_stable", 32'(tx_unstable), 32'd0);

        // RX flow control with the top level not consuming
        rx_allow = 1'b1; rx_ready = 1'b0;
        tick(2);
        check("rxf_en_on", 32'(bus.out_ctl_rx_en), 32'd1);
        for (int i = 0; i < 20; i++) rx_src[i] = 8'(8'h40 + i);
        rx_send_cnt = 20;
        tick(150);
        check("rxf_en_off",  32'(bus.out_ctl_rx_en), 32'd0);
        check("rxf_level",   32'(bus.out_rx_level), 32'd15);
        check("rxf_sent",    32'(rx_send_idx), 32'd15);
        check("rxf_valid",   32'(bus.out_rx_valid), 32'd1);
        check("rxf_head",    32'(bus.out_rx_byte), 32'h40);
        rx_ready = 1'b1;
        for (int i = 0; i < 400 && rx_got_n < 20; i++) tick();
        rx_ready = 1'b0;
        tick(2);
        check("rxf_got_n", 32'(rx_got_n), 32'd20);
        for (int i = 0; i < 20; i++) check("rxf_byte", 32'(rx_got[i]), 32'(8'h40 + i));
        check("rxf_level_0", 32'(bus.out_rx_level), 32'd0);
        check("rxf_en_back", 32'(bus.out_ctl_rx_en), 32'd1);

        // Simultaneous TX ack and RX req while the full RX FIFO is popped
        rx_auto = 1'b0; tx_auto = 1'b0;
        base = rx_got_n;
        for (int i = 0; i < 16; i++) rx_manual_byte(8'(8'h60 + i));
        check("sim_rx_full", 32'(bus.out_rx_level), 32'd16);
        tx_valid = 1'b1; tx_byte = 8'h77;
        tick();
        tx_valid = 1'b0;
        wait_tx_req("sim_tx_req");
        tx_ack_man = 1'b1; rx_data_man = 8'h70; rx_req_man = 1'b1; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("sim_tx_data",  32'(bus.out_ctl_tx_data), 32'h77);
        check("sim_tx_req_lo", 32'(bus.out_ctl_tx_hsk_req), 32'd0);
        check("sim_rx_ack",   32'(bus.out_ctl_rx_hsk_ack), 32'd1);
        check("sim_rx_level", 32'(bus.out_rx_level), 32'd16);
        check("sim_tx_level", 32'(bus.out_tx_level), 32'd0);
        check("sim_pop_n",    32'(rx_got_n - base), 32'd1);
        check("sim_pop_byte", 32'(rx_got[base]), 32'h60);
        tick();
        tx_ack_man = 1'b0; rx_req_man = 1'b0;
        wait_rx_ack(1'b0, "sim_rx_ack_lo");
        tick(3);
        check("sim_tx_got_n", 32'(tx_got_n), 32'd18);
        check("sim_tx_got",   32'(tx_got[17]), 32'h77);
        rx_ready = 1'b1;
        for (int i = 0; i < 100 && rx_got_n < base + 17; i++) tick();
        rx_ready = 1'b0;
        check("sim_drain_n", 32'(rx_got_n - base), 32'd17);
        for (int i = 0; i < 16; i++) check("sim_order", 32'(rx_got[base + i]), 32'(8'h60 + i));
        check("sim_last", 32'(rx_got[base + 16]), 32'h70);

        // Reset while TX is in REQ and RX is in ACK
        tx_valid = 1'b1; tx_byte = 8'h99;
        tick();
        tx_valid = 1'b0;
        wait_tx_req("rstm_tx_req");
        rx_data_man = 8'h55; rx_req_man = 1'b1;
        wait_rx_ack(1'b1, "rstm_rx_ack");
        check("rstm_pre_en",     32'(bus.out_ctl_rx_en), 32'd1);
        check("rstm_pre_txlvl",  32'(bus.out_tx_level), 32'd1);
        check("rstm_pre_rxlvl",  32'(bus.out_rx_level), 32'd1);
        rst = 1'b1;
        tick();
        check("rstm_tx_req",  32'(bus.out_ctl_tx_hsk_req), 32'd0);
        check("rstm_rx_ack",  32'(bus.out_ctl_rx_hsk_ack), 32'd0);
        check("rstm_tx_lvl",  32'(bus.out_tx_level), 32'd0);
        check("rstm_rx_lvl",  32'(bus.out_rx_level), 32'd0);
        check("rstm_tx_data", 32'(bus.out_ctl_tx_data), 32'h00);
        check("rstm_rx_en",   32'(bus.out_ctl_rx_en), 32'd0);
        check("rstm_ready",   32'(bus.out_tx_ready), 32'd1);
        rx_req_man = 1'b0;
        rst = 1'b0;
        tick(2);

        // RX master enable off with an empty FIFO; a pending req still gets acked
        check("allow_en_on", 32'(bus.out_ctl_rx_en), 32'd1);
        rx_allow = 1'b0;
        tick();
        check("allow_en_off", 32'(bus.out_ctl_rx_en), 32'd0);
        rx_data_man = 8'hC3; rx_req_man = 1'b1;
        wait_rx_ack(1'b1, "allow_ack");
        check("allow_level", 32'(bus.out_rx_level), 32'd1);
        rx_req_man = 1'b0;
        wait_rx_ack(1'b0, "allow_ack_lo");
        check("allow_valid", 32'(bus.out_rx_valid), 32'd1);
        check("allow_byte",  32'(bus.out_rx_byte), 32'hC3);
        check("allow_en_still_off", 32'(bus.out_ctl_rx_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ftdi_stream_bridge.md
Name: ftdi_stream_bridge

Overview:
- Sits between the FTDI byte controller (4-phase TX/RX interlock, 8-bit data) and the top-level logic.
- Converts the interlock handshakes into two buffered valid/ready byte streams, one TX FIFO and one RX FIFO.
- Drives the controller's RX-enable so that received bytes are never dropped.
- Holds TX data stable for the controller's whole write cycle.

Parameters:
- FIFO_AW, 4, address width of each FIFO; depth = 2**FIFO_AW entries (min 1).
- RX_HEADROOM, 2, minimum free RX FIFO entries required to keep RX enabled (min 2).

Ports:
- in_clk  input  1  clock
- in_rst  input  1  synchronous active-high reset
- in_tx_valid  input  1  top-level TX byte offered
- out_tx_ready  output  1  TX FIFO can accept a byte
- in_tx_byte  input  8  TX byte from top level
- out_rx_valid  output  1  RX FIFO head valid (first-word fall-through)
- in_rx_ready  input  1  top level consumes the RX head
- out_rx_byte  output  8  RX FIFO head byte
- in_rx_allow  input  1  top-level RX master enable
- out_ctl_tx_hsk_req  output  1  TX request to controller
- in_ctl_tx_hsk_ack  input  1  TX acknowledge from controller
- out_ctl_tx_data  output  8  TX byte to controller (registered)
- in_ctl_rx_hsk_req  input  1  RX request from controller
- out_ctl_rx_hsk_ack  output  1  RX acknowledge to controller
- in_ctl_rx_data  input  8  RX byte from controller
- out_ctl_rx_en  output  1  RX enable to controller (registered)
- out_tx_level  output  FIFO_AW+1  TX FIFO occupancy
- out_rx_level  output  FIFO_AW+1  RX FIFO occupancy

Behaviour:
- Reset values:
  - FIFOs empty, levels 0.
  - out_tx_ready=1, out_rx_valid=0, out_rx_byte=0.
  - All handshake outputs 0, out_ctl_tx_data=0, out_ctl_rx_en=0.
  - Both FSMs in IDLE.
- Reset mid-transfer abandons the byte in flight and drops req/ack the same cycle. The controller, reset from the same line, returns to its ready state.
- FIFO rules:
  - Push accepted iff not full; pop iff not empty.
  - Simultaneous push+pop: level unchanged; allowed when full (pop frees the slot) and when empty (bypass not required, the byte becomes head next cycle).
  - Pointers wrap modulo depth; level ranges 0..depth.
- TX FSM, states TX_IDLE, TX_REQ, TX_DROP:
  - TX_IDLE: if TX FIFO non-empty and ack==0, set req=1 and go to TX_REQ.
  - TX_REQ: hold req=1 until ack==1. On the ack-high cycle: load FIFO head into out_ctl_tx_data, pop, set req=0, go to TX_DROP.
  - TX_DROP: wait until ack==0, then go to TX_IDLE.
  - out_ctl_tx_data changes only on the ack-high cycle. At that point the controller has finished its previous write, so data stays stable through the controller's grant and hold phases.
  - Minimum 4 cycles per byte on the TX side.
- RX FSM, states RX_IDLE, RX_ACK:
  - RX_IDLE: if in_ctl_rx_hsk_req==1, push in_ctl_rx_data into the RX FIFO, set ack=1, go to RX_ACK.
  - RX_ACK: hold ack=1 until req==0, then ack=0 and go to RX_IDLE.
  - If the FIFO is full on a req, the ack is still issued, the byte is discarded, and a sticky internal overflow flag is set for simulation assertion. This must never occur given the headroom rule.
- out_ctl_rx_en is registered: 1 iff in_rx_allow and (depth - rx_level) >= RX_HEADROOM. It is therefore 1 cycle late, and the headroom absorbs one in-flight byte plus that lag.
- TX and RX FSMs are independent; simultaneous TX ack and RX req are both serviced the same cycle.
- Top-level TX/RX stream transfer occurs on valid&&ready at the clock edge; zero-latency ready.

Decomposition:
- Package ftdi_pkg:
  - FTDI_BYTE_W=8.
  - TX and RX FSM state encodings as localparams.
  - Default FIFO_AW.
- Sub-module byte_fifo (synchronous, FWFT, parameter AW), instantiated twice. The bridge holds only the two FSMs and the rx_en logic.

Test Plan:
- TX single byte: push 0xA5 with the ack model responding 1 cycle after req → req rises, out_ctl_tx_data=0xA5 on the ack cycle, req falls next cycle, tx_level 1→0.
- TX burst: push 0x01..0x10 back-to-back (FIFO_AW=4) → out_tx_ready=0 after 16 accepted bytes; controller model receives 0x01..0x10 in order; data never changes while req=0 after ack.
- RX flow control: controller model sends bytes with in_rx_ready=0 → out_ctl_rx_en falls when level reaches 15 (depth 16, headroom 2); an in-flight byte lands at level 15/16; no overflow; draining then resumes rx_en.
- Simultaneous: TX ack and RX req on the same cycle, with a top-level push+pop on a full RX FIFO → both handshakes progress, levels correct, byte order preserved.
- Reset mid-operation: assert in_rst while in TX_REQ and RX_ACK → next cycle all req/ack 0, levels 0, out_ctl_tx_data=0, out_ctl_rx_en=0.
- in_rx_allow=0 with an empty FIFO → out_ctl_rx_en=0 one cycle later; a pending controller req is still acknowledged.
